// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/ack data-memory
// port. It stalls the pipeline while an access is in flight and holds the
// aligned and extended load result for the MemToReg select. Byte order is
// big-endian, so byte offset 0 is bits [31:24].
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        sext_q, store_q, mis_q, berr_q;
  logic [7:0]  wcnt;

  logic        accept, mis_in, limit_hit;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wrep, ld_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign off       = addr_q[1:0];
  assign accept    = start & (mem_read | mem_write);
  assign mis_in    = (size == 2'b11)
                   | ((size == 2'b01) & addr[0])
                   | ((size == 2'b10) & (|addr[1:0]));
  // The counter holds the number of ack-less REQ cycles already elapsed, so
  // the current cycle is the last allowed one when it equals WAIT_LIMIT-1.
  assign limit_hit = (wcnt == 8'(WAIT_LIMIT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an ack in the limit cycle takes priority over timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = mis_in ? S_DONE : S_REQ;
      S_REQ:   if (dm_ack || limit_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, wait counter, error flags and load result register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      store_q   <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      wcnt      <= '0;
      load_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
            sext_q  <= sign_ext;
            store_q <= mem_write;
            mis_q   <= mis_in;
            berr_q  <= 1'b0;
            wcnt    <= '0;
          end
        end
        S_REQ: begin
          if (dm_ack) begin
            if (!store_q) load_data <= ld_ext;
          end else begin
            wcnt <= wcnt + 8'd1;
            if (limit_hit) berr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte enables and replicated store data from the latched request
  always_comb begin
    be   = '0;
    wrep = '0;
    case (size_q)
      2'b00: begin
        be   = 4'b1000 >> off;
        wrep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = off[1] ? 4'b0011 : 4'b1100;
        wrep = {2{wdata_q[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata_q;
      end
    endcase
  end

  // Load field selection and sign/zero extension
  always_comb begin
    byte_sel = '0;
    case (off)
      2'd0:    byte_sel = dm_rdata[31:24];
      2'd1:    byte_sel = dm_rdata[23:16];
      2'd2:    byte_sel = dm_rdata[15:8];
      default: byte_sel = dm_rdata[7:0];
    endcase
    half_sel = off[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    case (size_q)
      2'b00:   ld_ext = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      2'b01:   ld_ext = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      default: ld_ext = dm_rdata;
    endcase
  end

  // Outputs decoded from state; memory port is idle (all zero) outside REQ
  always_comb begin
    stall      = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_be      = '0;
    dm_wdata   = '0;
    case (state)
      S_IDLE: stall = accept;
      S_REQ: begin
        stall    = 1'b1;
        dm_req   = 1'b1;
        dm_we    = store_q;
        dm_addr  = {addr_q[31:2], 2'b00};
        dm_be    = be;
        dm_wdata = wrep;
      end
      S_DONE: begin
        done       = 1'b1;
        misaligned = mis_q;
        bus_err    = berr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives directed and random load/store transactions and
// checks every cycle against a transaction-level model of the access engine.
module tb_mem_access_unit;

  localparam int unsigned WL = 4;

  logic        clk = 1'b0;
  logic        rst, start, mem_read, mem_write, sign_ext, dm_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, dm_rdata;
  logic        stall, done, misaligned, bus_err, dm_req, dm_we;
  logic [31:0] load_data, dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  int          total = 0;
  int          bad = 0;
  logic [31:0] ld_model = '0;
  logic [31:0] obs_addr, obs_wd;
  logic [3:0]  obs_be;
  logic        obs_we, obs_berr, obs_mis;
  int          obs_req_cnt;

  mem_access_unit #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .addr(addr),
    .wdata(wdata), .stall(stall), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_load(logic [1:0] sz, logic [1:0] offs, logic sx, logic [31:0] r);
    int unsigned o, v, w;
    o = offs;
    if (sz == 2'b00) begin
      v = (r >> (8 * (3 - o))) & 32'd255;
      w = 8;
    end else if (sz == 2'b01) begin
      v = (r >> ((o >= 2) ? 0 : 16)) & 32'd65535;
      w = 16;
    end else begin
      return r;
    end
    if (sx && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
    return v;
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] sz, logic [1:0] offs);
    int unsigned o;
    o = offs;
    if (sz == 2'b00) return 4'(32'd1 << (3 - o));
    if (sz == 2'b01) return (o >= 2) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wd(logic [1:0] sz, logic [31:0] wd);
    if (sz == 2'b00) return (wd & 32'd255) * 32'h01010101;
    if (sz == 2'b01) return (wd & 32'd65535) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic m_mis(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic e_stall, e_done, e_mis, e_berr,
                            e_req, e_we, input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wd);
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".misaligned"}, 32'(misaligned), 32'(e_mis));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(e_berr));
    chk({tag, ".dm_req"}, 32'(dm_req), 32'(e_req));
    chk({tag, ".dm_we"}, 32'(dm_we), 32'(e_we));
    chk({tag, ".dm_addr"}, dm_addr, e_addr);
    chk({tag, ".dm_be"}, 32'(dm_be), 32'(e_be));
    chk({tag, ".dm_wdata"}, dm_wdata, e_wd);
    chk({tag, ".load_data"}, load_data, ld_model);
    if (dm_req === 1'b1) begin
      obs_req_cnt++;
      obs_addr = dm_addr;
      obs_be   = dm_be;
      obs_wd   = dm_wdata;
      obs_we   = dm_we;
    end
    if (done === 1'b1) begin
      obs_berr = bus_err;
      obs_mis  = misaligned;
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = '0; sign_ext = 1'b0;
    addr = '0; wdata = '0; dm_ack = 1'b0; dm_rdata = '0;
  endtask

  // While busy the request inputs either hold the original request or churn
  // randomly; both must be ignored until the unit is back in IDLE.
  task automatic busy_inputs(input logic hold);
    if (hold) begin
      start = 1'b1;
    end else begin
      start = 1'($urandom % 2); mem_read = 1'($urandom % 2); mem_write = 1'($urandom % 2);
      size = 2'($urandom % 4); sign_ext = 1'($urandom % 2);
      addr = $urandom; wdata = $urandom;
    end
  endtask

  // One transaction; d = REQ cycle number carrying dm_ack (0 or > WL: never)
  task automatic txn(input logic rd, wr, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, wd, rdat, input int d, input logic hold);
    logic acc, mis, ackd;
    int n_end;
    logic [31:0] ea, ew;
    logic [3:0] eb;
    acc  = rd | wr;
    mis  = m_mis(sz, a);
    ackd = (d >= 1 && d <= int'(WL));
    n_end = ackd ? d : int'(WL);
    ea = {a[31:2], 2'b00};
    eb = m_be(sz, a[1:0]);
    ew = m_wd(sz, wd);
    obs_req_cnt = 0; obs_berr = 1'b0; obs_mis = 1'b0;
    obs_addr = '0; obs_be = '0; obs_wd = '0; obs_we = 1'b0;
    start = 1'b1; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
    addr = a; wdata = wd; dm_ack = 1'($urandom % 2); dm_rdata = $urandom;
    expect_cyc("accept", acc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    if (!acc) begin
      cyc(); idle_inputs();
      return;
    end
    if (!mis) begin
      for (int k = 1; k <= n_end; k++) begin
        cyc(); busy_inputs(hold);
        dm_ack   = (k == d);
        dm_rdata = (k == d) ? rdat : $urandom;
        expect_cyc("req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, wr, ea, eb, ew);
      end
      if (ackd && !wr) ld_model = m_load(sz, a[1:0], sx, rdat);
    end
    cyc(); busy_inputs(hold);
    dm_ack = 1'($urandom % 2); dm_rdata = $urandom;
    expect_cyc("done", 1'b0, 1'b1, mis, !mis && !ackd, 1'b0, 1'b0, '0, '0, '0);
    cyc(); idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    cyc();
    expect_cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cyc();
    rst = 1'b0;

    // word load
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, '0, 32'hDEADBEEF, 1, 1'b0);
    chk("wl.load_data", load_data, 32'hDEADBEEF);
    chk("wl.dm_addr", obs_addr, 32'h100);
    chk("wl.dm_be", 32'(obs_be), 32'hF);
    // byte / half loads
    txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h101, '0, 32'h12F45678, 2, 1'b0);
    chk("lb.sext", load_data, 32'hFFFFFFF4);
    txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, '0, 32'h12F45678, 1, 1'b0);
    chk("lb.zext", load_data, 32'h000000F4);
    txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, '0, 32'h12F45678, 3, 1'b0);
    chk("lh.sext", load_data, 32'h00005678);
    // stores
    txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h203, 32'h000000AB, 32'h0BADF00D, 1, 1'b0);
    chk("sb.dm_addr", obs_addr, 32'h200);
    chk("sb.dm_be", 32'(obs_be), 32'h1);
    chk("sb.dm_wdata", obs_wd, 32'hABABABAB);
    chk("sb.dm_we", 32'(obs_we), 32'h1);
    chk("sb.load_data", load_data, 32'h00005678);
    txn(1'b1, 1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, '0, 2, 1'b0);
    chk("sh.dm_be", 32'(obs_be), 32'h3);
    chk("sh.dm_wdata", obs_wd, 32'h12341234);
    // misaligned
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, '0, '0, 1, 1'b0);
    chk("mis.req_cycles", 32'(obs_req_cnt), 32'd0);
    chk("mis.flag", 32'(obs_mis), 32'h1);
    txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, '0, '0, 1, 1'b0);
    chk("mis11.flag", 32'(obs_mis), 32'h1);
    // timeout and ack exactly at the limit
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, '0, '0, 0, 1'b0);
    chk("to.req_cycles", 32'(obs_req_cnt), 32'd4);
    chk("to.bus_err", 32'(obs_berr), 32'h1);
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, '0, 32'hCAFEF00D, 4, 1'b0);
    chk("lim.req_cycles", 32'(obs_req_cnt), 32'd4);
    chk("lim.bus_err", 32'(obs_berr), 32'h0);
    chk("lim.load_data", load_data, 32'hCAFEF00D);
    // start held through the access, and a strobe with no access type
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, '0, 32'h11223344, 2, 1'b1);
    chk("hold.req_cycles", 32'(obs_req_cnt), 32'd2);
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h600, '0, '0, 1, 1'b0);
    chk("noop.req_cycles", 32'(obs_req_cnt), 32'd0);

    // random transactions, back to back
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2 == 1) a[1:0] = 2'b00;
      txn(1'($urandom % 2), 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
          a, $urandom, $urandom, int'($urandom_range(0, 6)), 1'($urandom % 4 == 0));
    end

    // reset in the 2nd REQ cycle of an access whose ack would come in the 3rd
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, '0, 32'hDEADBEEF, 1, 1'b0);
    start = 1'b1; mem_read = 1'b1; size = 2'b10; addr = 32'h300;
    expect_cyc("rm.c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cyc(); start = 1'b0; mem_read = 1'b0;
    expect_cyc("rm.c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 4'hF, '0);
    cyc(); rst = 1'b1;
    expect_cyc("rm.c2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 4'hF, '0);
    ld_model = '0;
    cyc(); rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h55AA55AA;
    expect_cyc("rm.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cyc(); dm_ack = 1'b0;
    expect_cyc("rm.c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("rm.load_data", load_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
